// File: rtl/fmin_stream_reduce.sv
// fmin_stream_reduce
// Streaming FP32 minimum reduction over a valid/ready packet stream.
// Returns the minimum value (or canonical qNaN if any NaN was seen), the
// 0-based index of the selected beat and the packet beat count.
// Non-NaN operands are ordered with a sign-magnitude to unsigned key
// transform, so -Inf < negatives < -0 < +0 < positives < +Inf, and
// denormals compare by raw magnitude.

module fmin_stream_reduce #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_index,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan
);

  localparam logic [31:0]      CANON_QNAN = 32'h7FC0_0000;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Running accumulation
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_nan;

  logic [31:0]      w_acc_next;
  logic [CNT_W-1:0] w_idx_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_nan_next;

  // Registered result
  logic [31:0]      r_out_data;
  logic [CNT_W-1:0] r_out_index;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_nan;

  logic             w_accept;
  logic             w_done_load;
  logic             w_in_is_nan;
  logic             w_in_less;
  logic [CNT_W-1:0] w_cnt_inc;

  // Map an FP32 pattern onto an unsigned key that preserves the total
  // sign-magnitude order: negatives are bit-inverted (larger magnitude
  // becomes smaller key), positives get the top bit set.
  function automatic logic [31:0] f_order_key(input logic [31:0] v);
    return v[31] ? ~v : {1'b1, v[30:0]};
  endfunction

  function automatic logic f_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Handshake and per-beat decode
  assign in_ready    = rst_n && !clear && (r_state != DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_done_load = w_accept && in_last;
  assign w_in_is_nan = f_is_nan(in_data);
  assign w_in_less   = f_order_key(in_data) < f_order_key(r_acc);
  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  assign out_valid = (r_state == DONE);
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_count = r_out_count;
  assign out_nan   = r_out_nan;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; clear overrides everything and returns to IDLE
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_next = in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept && in_last) begin
            w_state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Accumulator update for the accepted beat
  always_comb begin
    w_acc_next = r_acc;
    w_idx_next = r_idx;
    w_cnt_next = r_cnt;
    w_nan_next = r_nan;
    if (w_accept) begin
      if (r_state == IDLE) begin
        w_acc_next = in_data;
        w_idx_next = '0;
        w_cnt_next = CNT_ONE;
        w_nan_next = w_in_is_nan;
      end else begin
        // Once a NaN has been seen the value and its index are frozen;
        // only the beat count keeps advancing.
        if (!r_nan) begin
          if (w_in_is_nan) begin
            w_nan_next = 1'b1;
            w_idx_next = r_cnt;
          end else if (w_in_less) begin
            w_acc_next = in_data;
            w_idx_next = r_cnt;
          end
        end
        w_cnt_next = w_cnt_inc;
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_nan <= 1'b0;
    end else if (clear) begin
      r_acc <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_nan <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_idx <= w_idx_next;
      r_cnt <= w_cnt_next;
      r_nan <= w_nan_next;
    end
  end

  // Result registers, loaded with the final accumulation on the last beat
  // so the result is presented in the same cycle out_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_count <= '0;
      r_out_nan   <= 1'b0;
    end else if (clear) begin
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_count <= '0;
      r_out_nan   <= 1'b0;
    end else if (w_done_load) begin
      r_out_data  <= w_nan_next ? CANON_QNAN : w_acc_next;
      r_out_index <= w_idx_next;
      r_out_count <= w_cnt_next;
      r_out_nan   <= w_nan_next;
    end
  end

endmodule

// File: tb/tb_fmin_stream_reduce.sv
// tb_fmin_stream_reduce
// Scoreboard bench: each packet's expected result is computed by a
// reference model and queued when the packet is driven, then popped and
// compared when the unit presents its result.

module tb_fmin_stream_reduce;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_index;
  logic [CNT_W-1:0] out_count;
  logic             out_nan;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] index;
    logic [31:0] count;
    logic        nan;
  } result_t;

  result_t exp_q[$];
  int n_compared;
  int n_mismatch;

  fmin_stream_reduce #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_count (out_count),
    .out_nan   (out_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  // a strictly below b in sign-magnitude order (both non-NaN)
  function automatic bit m_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic result_t model(input logic [31:0] beats[$]);
    result_t r;
    logic [31:0] acc;
    int idx, cnt;
    bit nan;
    acc = beats[0];
    idx = 0;
    cnt = 1;
    nan = m_is_nan(beats[0]);
    for (int i = 1; i < beats.size(); i++) begin
      if (!nan) begin
        if (m_is_nan(beats[i])) begin
          nan = 1;
          idx = cnt;
        end else if (m_less(beats[i], acc)) begin
          acc = beats[i];
          idx = cnt;
        end
      end
      if (cnt < CNT_MAX) cnt++;
    end
    r.data  = nan ? 32'h7FC0_0000 : acc;
    r.index = idx;
    r.count = cnt;
    r.nan   = nan;
    return r;
  endfunction

  // Drive one beat; called just after a rising edge, returns just after the
  // edge on which the beat was presented.
  task automatic drive_beat(input logic [31:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] beats[$]);
    exp_q.push_back(model(beats));
    for (int i = 0; i < beats.size(); i++) begin
      drive_beat(beats[i], i == beats.size() - 1);
    end
  endtask

  // Wait (bounded) for a result, compare it with the scoreboard head and
  // optionally complete the output handshake.
  task automatic collect(input string tag, input bit do_ack);
    result_t e;
    int waited;
    waited = 0;
    while (!out_valid && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".latency"}, waited, 0);
    if (exp_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".data"},  out_data, e.data);
      check({tag, ".index"}, {28'd0, out_index}, e.index);
      check({tag, ".count"}, {28'd0, out_count}, e.count);
      check({tag, ".nan"},   {31'd0, out_nan}, {31'd0, e.nan});
      $display("txn %s: data=0x%08h idx=%0d cnt=%0d nan=%0d", tag, out_data, out_index, out_count, out_nan);
    end
    if (do_ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".valid_after_ack"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".ready_after_ack"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  logic [31:0] pool [0:11];
  initial begin
    pool[0]  = 32'h0000_0000; pool[1]  = 32'h8000_0000;
    pool[2]  = 32'h7F80_0000; pool[3]  = 32'hFF80_0000;
    pool[4]  = 32'h0000_0001; pool[5]  = 32'h8000_0001;
    pool[6]  = 32'h3F80_0000; pool[7]  = 32'hBF80_0000;
    pool[8]  = 32'h7F80_0001; pool[9]  = 32'h4120_0000;
    pool[10] = 32'hC120_0000; pool[11] = 32'h007F_FFFF;
  end

  initial begin
    logic [31:0] pkt[$];
    logic [31:0] held;
    n_compared = 0;
    n_mismatch = 0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  {31'd0, in_ready}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_data",  out_data, 32'd0);
    check("rst.out_index", {28'd0, out_index}, 32'd0);
    check("rst.out_count", {28'd0, out_count}, 32'd0);
    check("rst.out_nan",   {31'd0, out_nan}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle.in_ready", {31'd0, in_ready}, 32'd1);

    pkt = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000};
    send_packet(pkt); collect("basic", 1);
    pkt = '{32'hBF80_0000, 32'hC000_0000, 32'hC000_0000};
    send_packet(pkt); collect("neg_tie", 1);
    pkt = '{32'h0000_0000, 32'h8000_0000};
    send_packet(pkt); collect("zero_pn", 1);
    pkt = '{32'h8000_0000, 32'h0000_0000};
    send_packet(pkt); collect("zero_np", 1);
    pkt = '{32'h3F80_0000, 32'h7F80_0001, 32'hC0A0_0000};
    send_packet(pkt); collect("nan_sticky", 1);
    pkt = '{32'h0000_0002, 32'h0000_0001, 32'h8000_0001, 32'h8000_0002};
    send_packet(pkt); collect("denorm", 1);

    // Backpressure with a pending beat that must not be consumed in DONE
    pkt = '{32'hFF80_0000};
    send_packet(pkt);
    collect("bp_single", 0);
    pkt = '{32'h3F80_0000};
    exp_q.push_back(model(pkt));
    in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b1;
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.in_ready",  {31'd0, in_ready}, 32'd0);
      check("bp.stable",    out_data, held);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp.ready_after_ack", {31'd0, in_ready}, 32'd1);
    @(posedge clk);   // pending beat accepted here
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    collect("bp_pending", 1);

    // Abort mid-packet with clear; the beat presented during clear is dropped
    drive_beat(32'hC000_0000, 0);
    drive_beat(32'h3F80_0000, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'hFF80_0000; in_last = 1'b0;
    #1;
    check("clear.in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    pkt = '{32'h4120_0000};
    send_packet(pkt); collect("after_clear", 1);

    // Clear drops an untaken result
    pkt = '{32'h4000_0000};
    send_packet(pkt); collect("clear_done", 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_done.out_valid", {31'd0, out_valid}, 32'd0);

    // Counter and index saturation (descending values, 20 beats)
    pkt = {};
    for (int i = 0; i < 20; i++) pkt.push_back(32'h4000_0000 - i);
    send_packet(pkt); collect("saturate", 1);

    // Randomised packets from a pool of corner values plus random bits
    for (int p = 0; p < 8; p++) begin
      pkt = {};
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        if ($urandom_range(0, 2) == 0) pkt.push_back($urandom);
        else pkt.push_back(pool[$urandom_range(0, 11)]);
      end
      send_packet(pkt); collect($sformatf("rand%0d", p), 1);
    end

    // Asynchronous reset mid-packet: everything drops, no result emerges
    drive_beat(32'h3F80_0000, 0);
    drive_beat(32'hBF80_0000, 0);
    in_valid = 1'b1; in_data = 32'h4000_0000; in_last = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.in_ready",  {31'd0, in_ready}, 32'd0);
    check("arst.out_valid", {31'd0, out_valid}, 32'd0);
    check("arst.out_data",  out_data, 32'd0);
    check("arst.out_count", {28'd0, out_count}, 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("arst.no_result", {31'd0, out_valid}, 32'd0);
    end

    check("scoreboard.drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/fmin_stream_reduce.md
# fmin_stream_reduce

Streaming FP32 minimum-reduction unit: accepts a packet of IEEE-754 single-precision values over a valid/ready stream and returns the minimum value, its position and the beat count once the packet ends. It is the min-side counterpart of the combinational FP max comparator in the FP execute cluster. It feeds vector-reduction (`vfredmin`-style) results back to the FP register writeback path.

## Interface
Parameters:
- `CNT_W`, default 16: width of the beat counter and index outputs.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous abort; highest priority after reset.
- `in_valid`  in  1: input beat valid.
- `in_data`  in  32: FP32 operand.
- `in_last`  in  1: final beat of the packet.
- `in_ready`  out  1: unit can accept a beat.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  32: minimum value, or canonical NaN.
- `out_index`  out  CNT_W: 0-based position of the selected beat.
- `out_count`  out  CNT_W: number of beats in the packet.
- `out_nan`  out  1: at least one NaN was seen in the packet.

## Operation
- FSM states are IDLE, ACCUM and DONE.
- `in_ready` is 1 in IDLE and ACCUM and 0 in DONE. `out_valid` is 1 only in DONE.
- A beat is accepted when `in_valid && in_ready` on a clock edge.
- IDLE, on an accepted beat:
  - acc ← `in_data`, idx ← 0, cnt ← 1, nan ← isNaN(`in_data`).
  - Go to DONE if `in_last`, else to ACCUM.
- ACCUM, on an accepted beat:
  - If `in_data` < acc, then acc ← `in_data` and idx ← cnt.
  - cnt ← cnt+1.
  - Then go to DONE if `in_last`.
- DONE:
  - Outputs are held stable.
  - On `out_valid && out_ready`, go to IDLE.
- Comparison rules:
  - NaN means exponent 0xFF and mantissa ≠ 0.
  - Non-NaN values follow a total sign-magnitude order: −Inf < negatives < −0 < +0 < positives < +Inf.
  - Denormals are compared bitwise by magnitude; there is no flush.
  - Ties on an identical bit pattern keep the earlier index (strict less-than).
- NaN rules:
  - The first NaN seen sets nan sticky and sets idx to that beat's index.
  - Once nan is set, acc and idx are frozen.
  - When nan is set, `out_data` = 0x7FC00000 (canonical qNaN) and `out_nan` = 1.
- cnt and idx saturate at 2^CNT_W−1. cnt never wraps.
- `clear` = 1:
  - Next state is IDLE and the accumulation is discarded.
  - `out_valid` drops, including in DONE with a result not yet taken.
  - The same-cycle input beat is not accepted: `in_ready` is forced to 0 while `clear` = 1.
- An `in_valid` beat while in DONE is not accepted; it stays pending.

## Timing
Reset values (asynchronous on `rst_n` low, held until release):
- State: IDLE.
- `in_ready` = 0 while `rst_n` = 0.
- `out_valid` = 0, `out_data` = 0, `out_index` = 0, `out_count` = 0, `out_nan` = 0.

Throughput and latency:
- Throughput is one beat per cycle in IDLE/ACCUM.
- `out_valid` rises on the cycle after the `in_last` beat is accepted (latency 1), with `out_data`, `out_index`, `out_count` and `out_nan` valid in that same cycle.
- Minimum turnaround from one packet's last beat to the next packet's first beat is 2 cycles: DONE plus `out_ready`, then IDLE.
- `out_*` are registered outputs. `in_ready` is decoded from the state register and `clear`.
- A single-beat packet (`in_last` on the first beat) goes from IDLE directly to DONE with count 1 and index 0.
- Asserting `rst_n` mid-packet drops all state immediately. No partial result is emitted.

## Test plan
1. **Basic minimum.** Send 0x40400000, 0x3F800000, 0x40000000 (last) → one cycle after the last beat, `out_data` = 0x3F800000, `out_index` = 1, `out_count` = 3, `out_nan` = 0.
2. **Negatives and ties.** Send 0xBF800000, 0xC0000000, 0xC0000000 (last) → `out_data` = 0xC0000000, `out_index` = 1 (earlier tie wins).
3. **Signed zeros.** Send 0x00000000, 0x80000000 (last) → `out_data` = 0x80000000, index 1. Reversed order → `out_data` = 0x80000000, index 0.
4. **NaN sticky.** Send 0x3F800000, 0x7F800001, 0xC0A00000 (last) → `out_data` = 0x7FC00000, `out_nan` = 1, `out_index` = 1, `out_count` = 3.
5. **Backpressure.** Send a single beat 0xFF800000 with `in_last`, then hold `out_ready` low for 5 cycles → `out_valid` = 1, outputs stable, `in_ready` = 0, and a pending `in_valid` beat is not consumed. On `out_ready` the unit returns to IDLE and `in_ready` = 1 the next cycle.
6. **Abort.** Send 2 beats, pulse `clear`, then send 0x41200000 (last) → result 0x41200000, count 1, index 0. Separately, drive `rst_n` low mid-packet → all outputs are zero and no `out_valid` appears.
